// File: rtl/io_uart_bridge.sv
// io_uart_bridge: device side of the CPU io port. Bytes written by the CPU are queued in a
// small FIFO and sent on a UART TX line; a UART RX line fills a one-byte holding register.
module io_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_wrOut,
  input  logic       i_inNOe,
  output logic [7:0] o_data,
  output logic       o_rxValid,
  output logic       o_rxOverrun,
  output logic       o_txFull,
  output logic       o_txBusy,
  input  logic       i_uartRx,
  output logic       o_uartTx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(TX_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    fifoMem [TX_DEPTH];
  logic [AW-1:0] fifoHead;
  logic [AW-1:0] fifoTail;
  logic [AW:0]   fifoCount;
  logic          txPush;
  logic          txPop;

  logic [1:0]    txState;
  logic [CW-1:0] txCnt;
  logic [2:0]    txBitIdx;
  logic [7:0]    txShift;

  logic          rxMeta;
  logic          rxSync;
  logic          rxPrev;
  logic [1:0]    rxState;
  logic [CW-1:0] rxCnt;
  logic [2:0]    rxBitIdx;
  logic [7:0]    rxShift;
  logic          rxWaitHigh;
  logic [7:0]    rxHold;
  logic          rxValid;
  logic          rxOverrun;
  logic          rxDeliver;
  logic          rxPopNow;

  // The full check uses the pre-edge count, so a pop in the same cycle does not free a slot.
  assign txPush = i_wrOut && (fifoCount != FIFO_FULL);
  assign txPop  = (txState == IDLE) && (fifoCount != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fifoHead  <= '0;
      fifoTail  <= '0;
      fifoCount <= '0;
    end else begin
      if (txPush) fifoTail <= fifoTail + AW'(1);
      if (txPop)  fifoHead <= fifoHead + AW'(1);
      if (txPush && !txPop)      fifoCount <= fifoCount + (AW + 1)'(1);
      else if (!txPush && txPop) fifoCount <= fifoCount - (AW + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (txPush) fifoMem[fifoTail] <= i_data;
  end

  // STOP holds one cycle short because the IDLE pass-through supplies the last stop cycle,
  // keeping back-to-back frames exactly 10 bit times apart.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      txState  <= IDLE;
      txCnt    <= '0;
      txBitIdx <= '0;
      txShift  <= '0;
      o_uartTx <= 1'b1;
    end else begin
      case (txState)
        IDLE: begin
          if (txPop) begin
            txShift <= fifoMem[fifoHead];
            txCnt   <= '0;
            txState <= START;
          end
        end
        START: begin
          if (txCnt == BIT_LAST) begin
            txCnt    <= '0;
            txBitIdx <= '0;
            txState  <= DATA;
          end else txCnt <= txCnt + CW'(1);
        end
        DATA: begin
          if (txCnt == BIT_LAST) begin
            txCnt   <= '0;
            txShift <= {1'b0, txShift[7:1]};
            if (txBitIdx == 3'd7) txState <= STOP;
            else txBitIdx <= txBitIdx + 3'd1;
          end else txCnt <= txCnt + CW'(1);
        end
        STOP: begin
          if (txCnt == STOP_LAST) begin
            txCnt   <= '0;
            txState <= IDLE;
          end else txCnt <= txCnt + CW'(1);
        end
        default: txState <= IDLE;
      endcase
      o_uartTx <= (txState == START) ? 1'b0 : (txState == DATA) ? txShift[0] : 1'b1;
    end
  end

  assign rxPopNow  = !i_inNOe && rxValid;
  assign rxDeliver = (rxState == STOP) && !rxWaitHigh && (rxCnt == BIT_LAST) && rxSync;

  // After a bad stop bit the receiver parks in STOP until the line is seen high again.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxMeta     <= 1'b1;
      rxSync     <= 1'b1;
      rxPrev     <= 1'b1;
      rxState    <= IDLE;
      rxCnt      <= '0;
      rxBitIdx   <= '0;
      rxShift    <= '0;
      rxWaitHigh <= 1'b0;
    end else begin
      rxMeta <= i_uartRx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      case (rxState)
        IDLE: begin
          if (rxPrev && !rxSync) begin
            rxCnt   <= '0;
            rxState <= START;
          end
        end
        START: begin
          if (rxCnt == HALF_LAST) begin
            rxCnt    <= '0;
            rxBitIdx <= '0;
            rxState  <= rxSync ? IDLE : DATA;
          end else rxCnt <= rxCnt + CW'(1);
        end
        DATA: begin
          if (rxCnt == BIT_LAST) begin
            rxCnt   <= '0;
            rxShift <= {rxSync, rxShift[7:1]};
            if (rxBitIdx == 3'd7) rxState <= STOP;
            else rxBitIdx <= rxBitIdx + 3'd1;
          end else rxCnt <= rxCnt + CW'(1);
        end
        STOP: begin
          if (rxWaitHigh) begin
            if (rxSync) begin
              rxWaitHigh <= 1'b0;
              rxState    <= IDLE;
            end
          end else if (rxCnt == BIT_LAST) begin
            rxCnt <= '0;
            if (rxSync) rxState <= IDLE;
            else rxWaitHigh <= 1'b1;
          end else rxCnt <= rxCnt + CW'(1);
        end
        default: rxState <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxHold    <= 8'h00;
      rxValid   <= 1'b0;
      rxOverrun <= 1'b0;
    end else if (rxDeliver) begin
      if (!rxValid || rxPopNow) begin
        rxHold  <= rxShift;
        rxValid <= 1'b1;
      end else rxOverrun <= 1'b1;
    end else if (rxPopNow) begin
      rxValid <= 1'b0;
    end
  end

  assign o_data      = i_inNOe ? 8'h00 : rxHold;
  assign o_rxValid   = rxValid;
  assign o_rxOverrun = rxOverrun;
  assign o_txFull    = (fifoCount == FIFO_FULL);
  assign o_txBusy    = (txState != IDLE) || (fifoCount != '0);

endmodule

// File: doc/io_uart_bridge.md
Name: io_uart_bridge

Overview:
- Device-side counterpart of the CPU io port. Consumes bytes the CPU writes with the output strobe, queues them and serializes them on a UART TX line.
- Deserializes a UART RX line into a one-byte holding register that the CPU reads onto the bus via the active-low input enable.
- Sits between the CPU io interface and the board's serial pins. Runs on the same clock as the CPU io logic.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be even and >= 4.
- TX_DEPTH, 4, TX FIFO depth in bytes; must be a power of 2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_data  in  8  byte from CPU bus; sampled when i_wrOut=1.
- i_wrOut  in  1  write strobe; one byte pushed per cycle in which it is high.
- i_inNOe  in  1  active-low read enable; low drives RX byte onto o_data and pops it.
- o_data  out  8  RX holding byte when i_inNOe=0, else 8'h00 (combinational).
- o_rxValid  out  1  holding register contains an unread byte.
- o_rxOverrun  out  1  sticky; a byte arrived while the holding register was full.
- o_txFull  out  1  TX FIFO holds TX_DEPTH bytes.
- o_txBusy  out  1  TX FSM not IDLE, or FIFO non-empty.
- i_uartRx  in  1  serial input, asynchronous, idle high.
- o_uartTx  out  1  serial output, idle high, registered.

Behaviour:
- Reset values: o_uartTx=1, o_rxValid=0, o_rxOverrun=0, o_txFull=0, o_txBusy=0. FIFO is emptied, both FSMs go to IDLE, the holding register is 8'h00 and all counters are 0.
- Reset has priority over every other event. Reset asserted mid-frame aborts the frame: o_uartTx returns to 1 on the next edge and the partial RX byte is lost.

TX path:
- Push: i_wrOut=1 and FIFO not full -> i_data is written at the tail.
- i_wrOut=1 while full -> byte is dropped and no state changes. The full check uses the pre-edge count, even if a pop occurs in the same cycle.
- TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START on the same edge.
- START: o_uartTx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP: o_uartTx=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back bytes have no extra idle gap: STOP -> IDLE -> START costs exactly one cycle.
- Latency from the push edge (empty FIFO, idle FSM): o_uartTx falls 2 edges later. A frame lasts 10*CLKS_PER_BIT cycles.

RX path:
- i_uartRx passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: a falling edge (1->0) on the synchronized line -> START, with the counter cleared.
- START: sample at CLKS_PER_BIT/2. If high, treat as a false start and return to IDLE. If low, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles from the mid-start point; 8 samples, LSB first.
- STOP: sample one bit later.
  - Sample=1 -> deliver the byte.
  - Sample=0 -> framing error: discard the byte and return to IDLE only after the line reads 1.
- Delivery rules:
  - o_rxValid=0 -> load the holding register and set o_rxValid.
  - o_rxValid=1 with no pop this cycle -> discard the byte and set o_rxOverrun.
- Pop: a rising edge with i_inNOe=0 and o_rxValid=1 clears o_rxValid.
- Delivery and pop on the same edge -> load the new byte, o_rxValid stays 1, no overrun.
- i_inNOe=0 with o_rxValid=0 -> o_data shows the stale holding value and there is no state change.
- o_rxOverrun clears only on reset.

Test Plan:
- CLKS_PER_BIT=4. Reset, then push 8'hA5 -> o_uartTx goes low 2 edges later, bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; o_txBusy falls after 40 frame cycles.
- TX_DEPTH=4. Push 6 bytes 8'h01..8'h06 on consecutive cycles with the line idle -> the first is popped immediately; 8'h06 is dropped (o_txFull high that cycle); 8'h01..8'h05 transmit back-to-back with no gap.
- Drive RX frame 8'h3C -> o_rxValid=1, o_data=8'h3C while i_inNOe=0; o_rxValid clears after one edge with i_inNOe=0; o_data=8'h00 when i_inNOe=1.
- Drive RX 8'h11 then 8'h22 without reading -> holding stays 8'h11 and o_rxOverrun=1. Separately, a pop on the exact delivery edge of 8'h22 -> holding=8'h22, o_rxValid=1, no overrun.
- RX glitch low for 1 cycle -> false start, no o_rxValid. Frame with stop bit 0 -> no delivery; the next valid frame 8'h7E is received correctly.
- Assert i_reset during TX DATA of 8'hFF and during RX DATA -> o_uartTx=1 on the next edge, FIFO empty, o_rxValid=0; a subsequent push transmits normally.
